// File: rtl/crack_pkg.sv
// Shared widths, state encoding and slice-bound helper for the password-cracker job dispatcher.
package crack_pkg;

    localparam int SYM_W           = 6;
    localparam int PWD_W           = 32;
    localparam int WID_W           = 4;
    localparam int DEFAULT_CHARSET = 36;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_WAIT     = 2'd2,
        ST_REPORT   = 2'd3
    } disp_state_t;

    // Last symbol of a slice starting at sym_first, clipped to the end of the charset.
    function automatic logic [SYM_W-1:0] slice_last(input logic [6:0] sym_first,
                                                    input int slice,
                                                    input int charset);
        logic [7:0] last;
        last = {1'b0, sym_first} + 8'(slice) - 8'd1;
        if (last > 8'(charset - 1)) begin
            last = 8'(charset - 1);
        end
        return last[SYM_W-1:0];
    endfunction

endpackage

// File: rtl/crack_worker_arbiter.sv
// Fixed-priority picker: lowest set request wins; one-hot grant plus its index, purely combinational.
module crack_worker_arbiter
    import crack_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [WID_W-1:0] idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = WID_W'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crack_job_dispatcher.sv
// Hands first-symbol slices to a worker pool and reports one overall search result.
// Offer is registered and held until accepted; at most one job accepted per cycle.
module crack_job_dispatcher
    import crack_pkg::*;
#(
    parameter int NUM_WORKERS    = 9,
    parameter int CHARSET        = DEFAULT_CHARSET,
    parameter int SLICE          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PWD_W-1:0]       password_in,
    output logic [PWD_W-1:0]       password_out,
    output logic [NUM_WORKERS-1:0] job_valid,
    input  logic [NUM_WORKERS-1:0] job_ready,
    output logic [SYM_W-1:0]       job_from,
    output logic [SYM_W-1:0]       job_to,
    input  logic [NUM_WORKERS-1:0] wrk_done,
    input  logic [NUM_WORKERS-1:0] wrk_found,
    output logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   found,
    output logic [WID_W-1:0]       found_worker,
    output logic                   timeout
);

    localparam logic [6:0]  CHARSET_L = 7'(CHARSET);
    localparam logic [6:0]  SLICE_L   = 7'(SLICE);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    disp_state_t            state;
    logic [NUM_WORKERS-1:0] worker_busy;
    logic [NUM_WORKERS-1:0] busy_nxt;
    logic [NUM_WORKERS-1:0] done_clr;
    logic [NUM_WORKERS-1:0] hit_vec;
    logic [NUM_WORKERS-1:0] idle_grant;
    logic [NUM_WORKERS-1:0] hit_grant;
    logic [WID_W-1:0]       idle_idx;
    logic [WID_W-1:0]       hit_idx;
    logic [6:0]             next_from;
    logic [6:0]             from_nxt;
    logic [15:0]            cycle_cnt;
    logic                   active;
    logic                   accept;
    logic                   idle_any;
    logic                   hit_any;
    logic                   arb_unused;

    // A worker accepting in this cycle is not yet busy, so its done/found pulses are ignored.
    always_comb begin
        active   = (state == ST_DISPATCH) || (state == ST_WAIT);
        accept   = |(job_valid & job_ready);
        done_clr = active ? (wrk_done & worker_busy) : '0;
        hit_vec  = active ? (wrk_found & worker_busy) : '0;
        busy_nxt = (worker_busy & ~done_clr) | (accept ? job_valid : '0);
        from_nxt = accept ? (next_from + SLICE_L) : next_from;
    end

    assign busy       = active;
    assign arb_unused = ^{idle_idx, hit_grant};

    crack_worker_arbiter #(.N(NUM_WORKERS)) u_idle_pick (
        .req   (~busy_nxt),
        .grant (idle_grant),
        .idx   (idle_idx),
        .any   (idle_any)
    );

    crack_worker_arbiter #(.N(NUM_WORKERS)) u_hit_pick (
        .req   (hit_vec),
        .grant (hit_grant),
        .idx   (hit_idx),
        .any   (hit_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            worker_busy  <= '0;
            next_from    <= '0;
            cycle_cnt    <= '0;
            password_out <= '0;
            job_valid    <= '0;
            job_from     <= '0;
            job_to       <= '0;
            abort        <= 1'b0;
            done         <= 1'b0;
            found        <= 1'b0;
            found_worker <= '0;
            timeout      <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        password_out <= password_in;
                        done         <= 1'b0;
                        found        <= 1'b0;
                        found_worker <= '0;
                        timeout      <= 1'b0;
                        worker_busy  <= '0;
                        next_from    <= '0;
                        cycle_cnt    <= '0;
                        job_valid    <= NUM_WORKERS'(1);
                        job_from     <= '0;
                        job_to       <= slice_last(7'd0, SLICE, CHARSET);
                        state        <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH, ST_WAIT: begin
                    worker_busy <= busy_nxt;
                    next_from   <= from_nxt;
                    cycle_cnt   <= cycle_cnt + 16'd1;
                    if (hit_any) begin
                        found        <= 1'b1;
                        found_worker <= hit_idx;
                        abort        <= 1'b1;
                        done         <= 1'b1;
                        job_valid    <= '0;
                        state        <= ST_REPORT;
                    end else if (cycle_cnt == TMO_LAST) begin
                        timeout   <= 1'b1;
                        abort     <= 1'b1;
                        done      <= 1'b1;
                        job_valid <= '0;
                        state     <= ST_REPORT;
                    end else if (state == ST_WAIT) begin
                        if (busy_nxt == '0) begin
                            done  <= 1'b1;
                            state <= ST_REPORT;
                        end
                    end else if (from_nxt >= CHARSET_L) begin
                        job_valid <= '0;
                        state     <= ST_WAIT;
                    end else if ((job_valid == '0) || accept) begin
                        // New offer only once the previous one is taken, so it never shifts under a waiting worker.
                        job_valid <= idle_any ? idle_grant : '0;
                        job_from  <= from_nxt[SYM_W-1:0];
                        job_to    <= slice_last(from_nxt, SLICE, CHARSET);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crack_job_dispatcher.sv
// Directed and randomised checks of crack_job_dispatcher against a slice/idle-set reference model.
module tb_crack_job_dispatcher;

    localparam int AW  = 9;
    localparam int ACS = 36;
    localparam int BW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic          a_start;
    logic [31:0]   a_pwd_in, a_pwd_out;
    logic [AW-1:0] a_jv, a_jr, a_wd, a_wf;
    logic [5:0]    a_jf, a_jt;
    logic          a_abort, a_busy, a_done, a_found, a_tmo;
    logic [3:0]    a_fw;

    logic          b_start;
    logic [31:0]   b_pwd_in, b_pwd_out;
    logic [BW-1:0] b_jv, b_jr, b_wd, b_wf;
    logic [5:0]    b_jf, b_jt;
    logic          b_abort, b_busy, b_done, b_found, b_tmo;
    logic [3:0]    b_fw;

    crack_job_dispatcher u_a (
        .clk(clk), .rst(rst), .start(a_start), .password_in(a_pwd_in), .password_out(a_pwd_out),
        .job_valid(a_jv), .job_ready(a_jr), .job_from(a_jf), .job_to(a_jt),
        .wrk_done(a_wd), .wrk_found(a_wf), .abort(a_abort), .busy(a_busy), .done(a_done),
        .found(a_found), .found_worker(a_fw), .timeout(a_tmo)
    );

    crack_job_dispatcher #(.NUM_WORKERS(BW), .CHARSET(10), .SLICE(4), .TIMEOUT_CYCLES(20)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .password_in(b_pwd_in), .password_out(b_pwd_out),
        .job_valid(b_jv), .job_ready(b_jr), .job_from(b_jf), .job_to(b_jt),
        .wrk_done(b_wd), .wrk_found(b_wf), .abort(b_abort), .busy(b_busy), .done(b_done),
        .found(b_found), .found_worker(b_fw), .timeout(b_tmo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_to(input int from, input int slice, input int cs);
        return (from + slice - 1 < cs - 1) ? (from + slice - 1) : (cs - 1);
    endfunction

    function automatic int lowest(input logic [AW-1:0] m);
        for (int i = 0; i < AW; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        a_start = 0; a_pwd_in = '0; a_jr = '0; a_wd = '0; a_wf = '0;
        b_start = 0; b_pwd_in = '0; b_jr = '0; b_wd = '0; b_wf = '0;
        tick(); tick();
        rst = 1'b0;
        n_cmp++;
        if ({a_pwd_out, a_jv, a_jf, a_jt} !== '0) begin
            n_bad++; $display("FAIL reset_a_job got=%h want=0", {a_pwd_out, a_jv, a_jf, a_jt});
        end
        n_cmp++;
        if ({a_abort, a_busy, a_done, a_found, a_fw, a_tmo} !== '0) begin
            n_bad++; $display("FAIL reset_a_flags got=%b want=0", {a_abort, a_busy, a_done, a_found, a_fw, a_tmo});
        end
        n_cmp++;
        if ({b_pwd_out, b_jv, b_jf, b_jt, b_abort, b_busy, b_done, b_found, b_fw, b_tmo} !== '0) begin
            n_bad++; $display("FAIL reset_b_all got=%h want=0",
                              {b_pwd_out, b_jv, b_jf, b_jt, b_abort, b_busy, b_done, b_found, b_fw, b_tmo});
        end
        tick();
        n_cmp++;
        if (a_busy !== 1'b0 || a_jv !== '0) begin
            n_bad++; $display("FAIL reset_idle busy=%b jv=%b want 0/0", a_busy, a_jv);
        end
    endtask

    task automatic test_exact_partition();
        logic [31:0] pwd;
        int order[AW];
        int tmp, j;
        pwd = $urandom;
        a_pwd_in = pwd; a_jr = '1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n_cmp++;
        if (a_busy !== 1'b1 || a_pwd_out !== pwd) begin
            n_bad++; $display("FAIL part_start busy=%b pwd=%h want 1 %h", a_busy, a_pwd_out, pwd);
        end
        for (int i = 0; i < AW; i++) begin
            n_cmp++;
            if (a_jv !== (AW'(1) << i) || a_jf !== 6'(4 * i) || a_jt !== 6'(exp_to(4 * i, 4, ACS))) begin
                n_bad++; $display("FAIL part_job%0d got jv=%b [%0d,%0d] want jv=%b [%0d,%0d]", i, a_jv, a_jf, a_jt,
                                  AW'(1) << i, 4 * i, exp_to(4 * i, 4, ACS));
            end
            tick();
        end
        n_cmp++;
        if (a_jv !== '0 || a_busy !== 1'b1 || a_done !== 1'b0) begin
            n_bad++; $display("FAIL part_wait jv=%b busy=%b done=%b want 0/1/0", a_jv, a_busy, a_done);
        end
        for (int i = 0; i < AW; i++) order[i] = i;
        for (int i = AW - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int k = 0; k < AW; k++) begin
            a_wd = AW'(1) << order[k];
            tick();
            a_wd = '0;
            n_cmp++;
            if (a_done !== (k == AW - 1)) begin
                n_bad++; $display("FAIL part_done_after%0d got=%b want=%b", k, a_done, k == AW - 1);
            end
        end
        n_cmp++;
        if (a_found !== 1'b0 || a_tmo !== 1'b0 || a_abort !== 1'b0 || a_busy !== 1'b0) begin
            n_bad++; $display("FAIL part_result found=%b tmo=%b abort=%b busy=%b want 0000", a_found, a_tmo, a_abort, a_busy);
        end
        tick();
        n_cmp++;
        if (a_done !== 1'b1 || a_busy !== 1'b0) begin
            n_bad++; $display("FAIL part_hold done=%b busy=%b want 1/0", a_done, a_busy);
        end
        a_jr = '0;
    endtask

    task automatic test_refill();
        b_pwd_in = $urandom; b_jr = 2'b11; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n_cmp++;
        if (b_jv !== 2'b01 || b_jf !== 6'd0 || b_jt !== 6'd3) begin
            n_bad++; $display("FAIL refill_j0 got %b [%0d,%0d] want 01 [0,3]", b_jv, b_jf, b_jt);
        end
        tick();
        n_cmp++;
        if (b_jv !== 2'b10 || b_jf !== 6'd4 || b_jt !== 6'd7) begin
            n_bad++; $display("FAIL refill_j1 got %b [%0d,%0d] want 10 [4,7]", b_jv, b_jf, b_jt);
        end
        tick();
        n_cmp++;
        if (b_jv !== 2'b00 || b_busy !== 1'b1) begin
            n_bad++; $display("FAIL refill_stall jv=%b busy=%b want 00/1", b_jv, b_busy);
        end
        b_wd = 2'b10;
        tick();
        b_wd = '0;
        n_cmp++;
        if (b_jv !== 2'b10 || b_jf !== 6'd8 || b_jt !== 6'd9) begin
            n_bad++; $display("FAIL refill_j2 got %b [%0d,%0d] want 10 [8,9]", b_jv, b_jf, b_jt);
        end
        tick();
        b_wd = 2'b01;
        tick();
        b_wd = '0;
        n_cmp++;
        if (b_jv !== 2'b00 || b_done !== 1'b0) begin
            n_bad++; $display("FAIL refill_partial jv=%b done=%b want 00/0", b_jv, b_done);
        end
        b_wd = 2'b10;
        tick();
        b_wd = '0;
        n_cmp++;
        if (b_done !== 1'b1 || b_found !== 1'b0 || b_tmo !== 1'b0) begin
            n_bad++; $display("FAIL refill_done done=%b found=%b tmo=%b want 1/0/0", b_done, b_found, b_tmo);
        end
        b_jr = '0;
        tick();
    endtask

    task automatic test_early_hit();
        a_pwd_in = $urandom; a_jr = '1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (AW) tick();
        a_wd = AW'(1) << 2;
        tick();
        a_wd = '0;
        a_wf = AW'(1) << 5;
        tick();
        a_wf = '0;
        n_cmp++;
        if (a_abort !== 1'b1 || a_found !== 1'b1 || a_fw !== 4'd5 || a_done !== 1'b1 || a_busy !== 1'b0 || a_tmo !== 1'b0) begin
            n_bad++; $display("FAIL hit_result abort=%b found=%b fw=%0d done=%b busy=%b tmo=%b want 1 1 5 1 0 0",
                              a_abort, a_found, a_fw, a_done, a_busy, a_tmo);
        end
        a_wd = '1;
        tick();
        a_wd = '0;
        n_cmp++;
        if (a_abort !== 1'b0 || a_done !== 1'b1 || a_found !== 1'b1 || a_fw !== 4'd5) begin
            n_bad++; $display("FAIL hit_hold abort=%b done=%b found=%b fw=%0d want 0 1 1 5", a_abort, a_done, a_found, a_fw);
        end
        a_jr = '0;
    endtask

    task automatic test_simultaneous();
        a_pwd_in = $urandom; a_jr = '1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (AW) tick();
        a_wf = (AW'(1) << 3) | (AW'(1) << 6);
        a_wd = AW'(1) << 3;
        tick();
        a_wf = '0; a_wd = '0;
        n_cmp++;
        if (a_found !== 1'b1 || a_fw !== 4'd3 || a_done !== 1'b1 || a_abort !== 1'b1) begin
            n_bad++; $display("FAIL simul found=%b fw=%0d done=%b abort=%b want 1 3 1 1", a_found, a_fw, a_done, a_abort);
        end
        a_jr = '0;
        tick();
    endtask

    task automatic test_backpressure_timeout();
        b_pwd_in = $urandom; b_jr = 2'b10; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int j = 0; j < 20; j++) begin
            n_cmp++;
            if (b_jv !== 2'b01 || b_jf !== 6'd0 || b_jt !== 6'd3 || b_abort !== 1'b0 || b_done !== 1'b0 || b_busy !== 1'b1) begin
                n_bad++; $display("FAIL bp_hold%0d jv=%b [%0d,%0d] abort=%b done=%b busy=%b want 01 [0,3] 0 0 1",
                                  j, b_jv, b_jf, b_jt, b_abort, b_done, b_busy);
            end
            tick();
        end
        n_cmp++;
        if (b_abort !== 1'b1 || b_tmo !== 1'b1 || b_done !== 1'b1 || b_found !== 1'b0 || b_busy !== 1'b0) begin
            n_bad++; $display("FAIL bp_timeout abort=%b tmo=%b done=%b found=%b busy=%b want 1 1 1 0 0",
                              b_abort, b_tmo, b_done, b_found, b_busy);
        end
        tick();
        n_cmp++;
        if (b_abort !== 1'b0 || b_tmo !== 1'b1 || b_done !== 1'b1) begin
            n_bad++; $display("FAIL bp_hold_after abort=%b tmo=%b done=%b want 0 1 1", b_abort, b_tmo, b_done);
        end
        b_jr = '0;
    endtask

    task automatic test_random();
        logic [AW-1:0] m_busy, m_offer, jr, wd, wf, hit;
        int  m_next, hit_at, w;
        bit  acc, finished;
        for (int it = 0; it < 10; it++) begin
            a_pwd_in = $urandom; a_start = 1'b1;
            tick();
            a_start = 1'b0;
            m_busy = '0; m_next = 0; m_offer = AW'(1);
            hit_at = (it % 2 == 0) ? int'($urandom_range(40, 2)) : -1;
            finished = 1'b0;
            for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
                n_cmp++;
                if (a_jv !== m_offer || a_done !== 1'b0 || a_busy !== 1'b1 ||
                    (m_offer != '0 && (a_jf !== 6'(m_next) || a_jt !== 6'(exp_to(m_next, 4, ACS))))) begin
                    n_bad++; $display("FAIL rnd%0d_c%0d jv=%b [%0d,%0d] done=%b busy=%b want jv=%b [%0d,%0d] 0 1", it, cyc,
                                      a_jv, a_jf, a_jt, a_done, a_busy, m_offer, m_next, exp_to(m_next, 4, ACS));
                end
                jr = AW'($urandom);
                wd = AW'($urandom & $urandom);
                wf = (cyc == hit_at) ? (AW'(1) << $urandom_range(AW - 1, 0)) : '0;
                a_jr = jr; a_wd = wd; a_wf = wf;
                tick();
                a_wd = '0; a_wf = '0;
                hit = wf & m_busy;
                if (hit != '0) begin
                    finished = 1'b1;
                    n_cmp++;
                    if (a_found !== 1'b1 || a_fw !== 4'(lowest(hit)) || a_abort !== 1'b1 || a_done !== 1'b1) begin
                        n_bad++; $display("FAIL rnd%0d_hit found=%b fw=%0d abort=%b done=%b want 1 %0d 1 1",
                                          it, a_found, a_fw, a_abort, a_done, lowest(hit));
                    end
                end else begin
                    acc    = (m_offer & jr) != '0;
                    m_busy = (m_busy & ~wd) | (acc ? m_offer : '0);
                    if (acc) m_next += 4;
                    if (m_next >= ACS) begin
                        m_offer = '0;
                        if (m_busy == '0) begin
                            finished = 1'b1;
                            n_cmp++;
                            if (a_done !== 1'b1 || a_found !== 1'b0 || a_abort !== 1'b0 || a_tmo !== 1'b0) begin
                                n_bad++; $display("FAIL rnd%0d_end done=%b found=%b abort=%b tmo=%b want 1 0 0 0",
                                                  it, a_done, a_found, a_abort, a_tmo);
                            end
                        end
                    end else if (m_offer == '0 || acc) begin
                        w = lowest(~m_busy);
                        m_offer = (w < 0) ? '0 : (AW'(1) << w);
                    end
                end
            end
            if (!finished) begin
                n_cmp++; n_bad++;
                $display("FAIL rnd%0d_bound search did not end in 600 cycles, want completion", it);
            end
            a_jr = '0;
            tick();
        end
    endtask

    task automatic test_reset_busy_start();
        logic [31:0] p1, p2;
        p1 = $urandom | 32'h1;
        p2 = ~p1;
        a_pwd_in = p1; a_jr = '0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        a_pwd_in = p2; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n_cmp++;
        if (a_pwd_out !== p1 || a_jv !== AW'(1) || a_busy !== 1'b1) begin
            n_bad++; $display("FAIL busy_start pwd=%h jv=%b busy=%b want %h 1 1", a_pwd_out, a_jv, a_busy, p1);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({a_pwd_out, a_jv, a_jf, a_jt, a_abort, a_busy, a_done, a_found, a_fw, a_tmo} !== '0) begin
            n_bad++; $display("FAIL midrst_outputs got=%h want=0",
                              {a_pwd_out, a_jv, a_jf, a_jt, a_abort, a_busy, a_done, a_found, a_fw, a_tmo});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (a_abort !== 1'b0 || a_busy !== 1'b0 || a_jv !== '0) begin
            n_bad++; $display("FAIL midrst_idle abort=%b busy=%b jv=%b want 0 0 0", a_abort, a_busy, a_jv);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_exact_partition();
        test_refill();
        test_early_hit();
        test_simultaneous();
        test_backpressure_timeout();
        test_random();
        test_reset_busy_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/crack_job_dispatcher.md
# crack_job_dispatcher

- **Role:** initiator-side controller for the brute-force password crackers.
- **Function:** accepts a target password and splits the first-character search space (symbol indices 0..CHARSET-1) into slices of SLICE symbols. Hands slices to a pool of worker crackers over a valid/ready job handshake, refilling workers as they finish.
- **Completion:** collects worker found/done results and aborts all workers on the first hit or on timeout. Reports one overall result.
- **Placement:** sits between the host/test harness and the parallel cracker array. It replaces fixed per-instance from/to ranges with dynamic allocation.

## Interface
- NUM_WORKERS, 9, number of cracker workers (1..15)
- CHARSET, 36, symbols per password character
- SLICE, 4, first-character symbols per job (>=1)
- TIMEOUT_CYCLES, 65535, cycle limit per search (16-bit counter)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; latches password_in; ignored while busy
- password_in  in  32  target, 4 ASCII chars
- password_out  out  32  latched target, broadcast to all workers
- job_valid  out  NUM_WORKERS  one-hot job offer to worker i
- job_ready  in  NUM_WORKERS  worker i accepts a job
- job_from  out  6  first symbol of offered slice
- job_to  out  6  last symbol of offered slice, inclusive
- wrk_done  in  NUM_WORKERS  1-cycle pulse: worker i exhausted its slice
- wrk_found  in  NUM_WORKERS  1-cycle pulse: worker i matched
- abort  out  1  1-cycle pulse: all workers stop and return to idle
- busy  out  1  search in progress
- done  out  1  search finished; held until next accepted start
- found  out  1  match found; held with done
- found_worker  out  4  index of matching worker; held with done
- timeout  out  1  search ended by timeout; held with done

## Operation
- FSM states: IDLE, DISPATCH, WAIT, REPORT.
- **IDLE:** start=1 latches password_out, clears done/found/timeout/found_worker, next_from=0, sets all workers idle -> DISPATCH.
- **DISPATCH:** while next_from<CHARSET and any worker is idle, offer one job to the lowest-index idle worker.
  - Slice bounds: job_from=next_from, job_to=min(next_from+SLICE-1, CHARSET-1).
  - On job_valid&job_ready: mark the worker busy and set next_from += SLICE (7-bit arithmetic, no wrap).
  - When next_from>=CHARSET -> WAIT.
- **Worker tracking:** in DISPATCH and WAIT, wrk_done[i] on a busy worker marks it idle. wrk_done on an idle worker is ignored.
- **Completion:** in WAIT, all workers idle -> REPORT with found=0.
- **Hit:** any wrk_found[i] on a busy worker (DISPATCH or WAIT):
  - found=1, found_worker=lowest such i, abort pulse, -> REPORT.
  - found beats wrk_done in the same cycle, even from the same worker.
- **Timeout:** cycle counter runs in DISPATCH/WAIT. Reaching TIMEOUT_CYCLES -> abort pulse, timeout=1, found=0, -> REPORT. A wrk_found in that same cycle wins (found=1, timeout=0).
- **REPORT:** done=1; returns to IDLE next cycle. done, found, found_worker and timeout stay held in IDLE until the next start.
- Reset values of all outputs are 0. This includes password_out, job_from and job_to.
- rst mid-search: the FSM returns to IDLE immediately and no abort pulse is generated. Workers share rst.

## Timing
- start in cycle T -> busy=1 in T+1; first job_valid in T+1.
- At most one job_valid bit is high per cycle.
- job_valid, job_from and job_to stay stable until ready.
- Dispatch rate is at most one accepted job per cycle.
- The offer moves to the next idle worker the cycle after acceptance.
- wrk_found in cycle T -> abort=1, done=1 and found=1 in T+1; busy=0 in T+1.
- Last wrk_done in WAIT at cycle T -> done=1 in T+1.
- Timeout fires when the counter, cleared at start, reaches TIMEOUT_CYCLES cycles after entering DISPATCH.

## Structure
- crack_pkg holds:
  - SYM_W=6 and PWD_W=32 constants;
  - the dispatcher state enum;
  - the default CHARSET.
- Sub-module crack_worker_arbiter: a fixed-priority lowest-index picker that returns the one-hot grant plus an index. It is reused for both idle-worker selection and found_worker encoding.

## Test plan
- **Exact partition.** Defaults, all job_ready=1, no found. Expected:
  - 9 jobs [0,3]..[32,35] go to workers 0..8 in consecutive cycles.
  - After all wrk_done pulses, done=1, found=0 one cycle after the last pulse.
- **Refill.** NUM_WORKERS=2, CHARSET=10, SLICE=4. Expected:
  - jobs [0,3]->w0 and [4,7]->w1;
  - wrk_done[1] -> [8,9] offered to w1;
  - done after both workers finish.
- **Early hit.** wrk_found[5] during WAIT. Expected:
  - next cycle abort=1, found=1, found_worker=5, done=1;
  - later wrk_done pulses have no effect.
- **Simultaneous events.** wrk_found[3] and wrk_found[6] in the same cycle, plus wrk_done[3]. Expected: found_worker=3 and found=1.
- **Backpressure and timeout.** TIMEOUT_CYCLES=20 with job_ready[0]=0 held. Expected:
  - job_valid[0] stays asserted with job_from=0, job_to=3;
  - cycle 20 gives abort, timeout=1, done=1, found=0.
- **Reset and busy start.** Assert rst mid-DISPATCH. Expected:
  - next cycle all outputs are 0 and the FSM is in IDLE;
  - a start while busy is ignored (password_out unchanged).
